// File: rtl/i2c_wb_sequencer.sv
// i2c_wb_sequencer: Wishbone master that drives the byte-level I2C controller
// (CSR/DPR/CMDR/FSMR register map) through complete I2C transactions.
// Optional build macro I2C_SEQ_POLL_EN: ignore irq_i and poll CMDR for completion
// (CSR is then programmed with interrupts disabled).
module i2c_wb_sequencer #(
    parameter int MAX_LEN = 16,
    parameter int BUS_W   = 4,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_rw_i,
    input  logic [6:0]       req_addr_i,
    input  logic [BUS_W-1:0] req_bus_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [7:0]       wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             done_o,
    output logic [1:0]       err_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [1:0]       adr_o,
    output logic [7:0]       dat_o,
    input  logic [7:0]       dat_i,
    input  logic             ack_i,
    input  logic             irq_i
);

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_RD_ACK  = 8'h02;
    localparam logic [7:0] CMD_RD_NAK  = 8'h03;
    localparam logic [7:0] CMD_START   = 8'h04;
    localparam logic [7:0] CMD_STOP    = 8'h05;
    localparam logic [7:0] CMD_SET_BUS = 8'h06;

`ifdef I2C_SEQ_POLL_EN
    localparam logic [7:0] CSR_INIT = 8'h80;
`else
    localparam logic [7:0] CSR_INIT = 8'hC0;
`endif

    typedef enum logic [4:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUS_DPR,
        ST_BUS_CMD,
        ST_START_CMD,
        ST_ADDR_DPR,
        ST_ADDR_CMD,
        ST_WR_WAIT,
        ST_WR_DPR,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_RD_DPR,
        ST_STOP_CMD,
        ST_WAIT_IRQ,
        ST_WAIT_RD,
        ST_POLL_GAP,
        ST_DONE
    } state_t;

    // Which controller command the WAIT states are waiting on
    typedef enum logic [2:0] {
        OP_SETBUS,
        OP_START,
        OP_ADDR,
        OP_WR,
        OP_RD,
        OP_STOP
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic [6:0]       addr_q, addr_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic [7:0]       wbyte_q, wbyte_d;
    logic [1:0]       err_q, err_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [1:0]       adr_q, adr_d;
    logic [7:0]       dat_q, dat_d;
    logic             req_ready_q, req_ready_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             done_q, done_d;

    logic             acc_go;
    logic             acc_we;
    logic [1:0]       acc_adr;
    logic [7:0]       acc_dat;
    logic             acc_done;
    logic [LEN_W-1:0] len_clip;
    logic             st_don, st_nak, st_al, st_err;

`ifdef I2C_SEQ_POLL_EN
    logic unused_irq;
    assign unused_irq = irq_i;
`endif

    assign acc_done = cyc_q & ack_i;
    assign len_clip = (req_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len_i;
    assign st_don   = dat_i[7];
    assign st_nak   = dat_i[6];
    assign st_al    = dat_i[5];
    assign st_err   = dat_i[4];

    // State and output registers, all cleared asynchronously by reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_INIT;
            op_q        <= OP_SETBUS;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            bus_q       <= '0;
            wbyte_q     <= '0;
            err_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            bus_q       <= bus_d;
            wbyte_q     <= wbyte_d;
            err_q       <= err_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
        end
    end

    // Sequencer next state plus the shared Wishbone access engine
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        bus_d      = bus_q;
        wbyte_d    = wbyte_q;
        err_d      = err_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        acc_go     = 1'b0;
        acc_we     = 1'b0;
        acc_adr    = ADR_CSR;
        acc_dat    = 8'h00;

        case (state_q)
            ST_INIT: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CSR;
                acc_dat = CSR_INIT;
                if (acc_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    rw_d    = req_rw_i;
                    addr_d  = req_addr_i;
                    bus_d   = req_bus_i;
                    cnt_d   = len_clip;
                    err_d   = 2'd0;
                    state_d = ST_BUS_DPR;
                end
            end
            ST_BUS_DPR: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_DPR;
                acc_dat = 8'(bus_q);
                if (acc_done) state_d = ST_BUS_CMD;
            end
            ST_BUS_CMD: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CMDR;
                acc_dat = CMD_SET_BUS;
                if (acc_done) begin
                    op_d    = OP_SETBUS;
                    state_d = ST_WAIT_IRQ;
                end
            end
            ST_START_CMD: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CMDR;
                acc_dat = CMD_START;
                if (acc_done) begin
                    op_d    = OP_START;
                    state_d = ST_WAIT_IRQ;
                end
            end
            ST_ADDR_DPR: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_DPR;
                acc_dat = {addr_q, rw_q};
                if (acc_done) state_d = ST_ADDR_CMD;
            end
            ST_ADDR_CMD: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CMDR;
                acc_dat = CMD_WRITE;
                if (acc_done) begin
                    op_d    = OP_ADDR;
                    state_d = ST_WAIT_IRQ;
                end
            end
            ST_WR_WAIT: begin
                if (wr_valid_i) begin
                    wbyte_d    = wr_data_i;
                    wr_ready_d = 1'b1;
                    state_d    = ST_WR_DPR;
                end
            end
            ST_WR_DPR: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_DPR;
                acc_dat = wbyte_q;
                if (acc_done) state_d = ST_WR_CMD;
            end
            ST_WR_CMD: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CMDR;
                acc_dat = CMD_WRITE;
                if (acc_done) begin
                    op_d    = OP_WR;
                    state_d = ST_WAIT_IRQ;
                end
            end
            ST_RD_CMD: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CMDR;
                acc_dat = (cnt_q == LEN_W'(1)) ? CMD_RD_NAK : CMD_RD_ACK;
                if (acc_done) begin
                    op_d    = OP_RD;
                    state_d = ST_WAIT_IRQ;
                end
            end
            ST_RD_DPR: begin
                acc_go  = 1'b1;
                acc_adr = ADR_DPR;
                if (acc_done) begin
                    rd_data_d  = dat_i;
                    rd_valid_d = 1'b1;
                    cnt_d      = cnt_q - LEN_W'(1);
                    state_d    = (cnt_q == LEN_W'(1)) ? ST_STOP_CMD : ST_RD_CMD;
                end
            end
            ST_STOP_CMD: begin
                acc_go  = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ADR_CMDR;
                acc_dat = CMD_STOP;
                if (acc_done) begin
                    op_d    = OP_STOP;
                    state_d = ST_WAIT_IRQ;
                end
            end
            ST_WAIT_IRQ: begin
`ifdef I2C_SEQ_POLL_EN
                state_d = ST_WAIT_RD;
`else
                if (irq_i) state_d = ST_WAIT_RD;
`endif
            end
            ST_WAIT_RD: begin
                acc_go  = 1'b1;
                acc_adr = ADR_CMDR;
                if (acc_done) begin
                    if (st_al) begin
                        err_d   = 2'd2;
                        state_d = ST_DONE;
                    end else if (st_err) begin
                        err_d   = 2'd3;
                        state_d = ST_DONE;
                    end else if (st_nak) begin
                        err_d   = 2'd1;
                        state_d = (op_q == OP_STOP) ? ST_DONE : ST_STOP_CMD;
                    end else if (st_don) begin
                        case (op_q)
                            OP_SETBUS: state_d = ST_START_CMD;
                            OP_START:  state_d = ST_ADDR_DPR;
                            OP_ADDR: begin
                                if (cnt_q == '0) state_d = ST_STOP_CMD;
                                else if (rw_q)   state_d = ST_RD_CMD;
                                else             state_d = ST_WR_WAIT;
                            end
                            OP_WR: begin
                                cnt_d   = cnt_q - LEN_W'(1);
                                state_d = (cnt_q == LEN_W'(1)) ? ST_STOP_CMD : ST_WR_WAIT;
                            end
                            OP_RD:   state_d = ST_RD_DPR;
                            default: state_d = ST_DONE;
                        endcase
                    end else begin
`ifdef I2C_SEQ_POLL_EN
                        state_d = ST_POLL_GAP;
`else
                        state_d = ST_WAIT_IRQ;
`endif
                    end
                end
            end
            ST_POLL_GAP: begin
                state_d = ST_WAIT_RD;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (cyc_q) begin
            if (ack_i) begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
                we_d  = 1'b0;
            end
        end else if (acc_go) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_dat;
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    assign req_ready_o = req_ready_q;
    assign wr_ready_o  = wr_ready_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;

endmodule
